// File: rtl/pwm_rgb_encoder_pkg.sv
// Shared widths, duty type and the per-channel on/off rule for the RGB PWM encoder.
package pwm_pkg;

    localparam int PWM_BITS  = 8;
    localparam int PWM_STEPS = 256;

    typedef logic [PWM_BITS-1:0] duty_t;

    localparam duty_t DUTY_FULL = 8'hFF;
    localparam duty_t STEP_LAST = duty_t'(PWM_STEPS - 1);

    // Full-scale duty means steady on; otherwise on for the first 'duty' steps.
    function automatic logic duty_on(input duty_t duty, input duty_t step);
        return (duty == DUTY_FULL) || (step < duty);
    endfunction

endpackage

// File: rtl/pwm_rgb_encoder_channel.sv
// One colour channel: double-buffered active duty plus the registered compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  wrap,
    input  duty_t step_cnt,
    input  duty_t duty_in,
    output logic  pwm_out
);

    duty_t duty_act;

    // Active duty tracks the input while idle and is only reloaded at a period wrap while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_act <= '0;
        end else if (!en || wrap) begin
            duty_act <= duty_in;
        end
    end

    // ---- compare stage: output lags step/duty by one clock, inactive while idle ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= ACTIVE_LOW;
        end else if (!en) begin
            pwm_out <= ACTIVE_LOW;
        end else begin
            pwm_out <= duty_on(duty_act, step_cnt) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/pwm_rgb_encoder.sv
// Three-channel PWM encoder for the RGB LED: prescaler, 256-step period counter,
// wrap/period_start generation and three pwm_channel instances.
module pwm_rgb_encoder
    import pwm_pkg::*;
#(
    parameter int CLK_DIV    = 100,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] r_duty,
    input  logic [7:0] g_duty,
    input  logic [7:0] b_duty,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start
);

    // A 1-bit prescaler is kept for CLK_DIV=1; it simply stays at 0 and ticks every cycle.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    duty_t            step_cnt;
    logic             tick;
    logic             wrap;

    assign tick = (div_cnt == DIV_LAST);
    // Idle overrides a wrap, so nothing is reloaded or pulsed while en is low.
    assign wrap = en && tick && (step_cnt == STEP_LAST);

    // Prescaler and step counter; both held at zero while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (!en) begin
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            step_cnt <= step_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // ---- boundary stage: pulse lands on the first cycle of the new period ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk(clk), .rst(rst), .en(en), .wrap(wrap),
        .step_cnt(step_cnt), .duty_in(r_duty), .pwm_out(pwm_r)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk(clk), .rst(rst), .en(en), .wrap(wrap),
        .step_cnt(step_cnt), .duty_in(g_duty), .pwm_out(pwm_g)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk(clk), .rst(rst), .en(en), .wrap(wrap),
        .step_cnt(step_cnt), .duty_in(b_duty), .pwm_out(pwm_b)
    );

endmodule

// File: tb/tb_pwm_rgb_encoder.sv
// Bench for pwm_rgb_encoder: three instances (CLK_DIV 1/4/3, the last active-low) share
// stimulus; a cycle-position model predicts every output and literal counts pin the model.
module tb_pwm_rgb_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] r_duty = '0;
    logic [7:0] g_duty = '0;
    logic [7:0] b_duty = '0;

    logic pr_a, pg_a, pb_a, ps_a;
    logic pr_b, pg_b, pb_b, ps_b;
    logic pr_c, pg_c, pb_c, ps_c;

    logic [3:0] dut_o [3];
    assign dut_o[0] = {pr_a, pg_a, pb_a, ps_a};
    assign dut_o[1] = {pr_b, pg_b, pb_b, ps_b};
    assign dut_o[2] = {pr_c, pg_c, pb_c, ps_c};

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pwm_rgb_encoder #(.CLK_DIV(1), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .pwm_r(pr_a), .pwm_g(pg_a), .pwm_b(pb_a), .period_start(ps_a)
    );
    pwm_rgb_encoder #(.CLK_DIV(4), .ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .pwm_r(pr_b), .pwm_g(pg_b), .pwm_b(pb_b), .period_start(ps_b)
    );
    pwm_rgb_encoder #(.CLK_DIV(3), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
        .pwm_r(pr_c), .pwm_g(pg_c), .pwm_b(pb_c), .period_start(ps_c)
    );

    function automatic int div_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic al_of(input int k);
        return (k == 2);
    endfunction

    function automatic logic lit(input int d, input int s);
        return (d == 255) || (s < d);
    endfunction

    // Model: one cycle position within the period per instance; step = position / CLK_DIV.
    int         m_cnt [3];
    int         m_dr  [3];
    int         m_dg  [3];
    int         m_db  [3];
    logic [3:0] m_exp [3];

    always @(posedge clk or negedge rst) begin
        int   s, per;
        logic al;
        for (int k = 0; k < 3; k++) begin
            al  = al_of(k);
            per = 256 * div_of(k);
            if (!rst) begin
                m_cnt[k] = 0;
                m_dr[k] = 0; m_dg[k] = 0; m_db[k] = 0;
                m_exp[k] = {al, al, al, 1'b0};
            end else if (!en) begin
                m_cnt[k] = 0;
                m_dr[k] = r_duty; m_dg[k] = g_duty; m_db[k] = b_duty;
                m_exp[k] = {al, al, al, 1'b0};
            end else begin
                s = m_cnt[k] / div_of(k);
                m_exp[k] = {lit(m_dr[k], s) ^ al, lit(m_dg[k], s) ^ al,
                            lit(m_db[k], s) ^ al, (m_cnt[k] == per - 1)};
                if (m_cnt[k] == per - 1) begin
                    m_dr[k] = r_duty; m_dg[k] = g_duty; m_db[k] = b_duty;
                end
                m_cnt[k] = (m_cnt[k] + 1) % per;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_o[k] !== m_exp[k]) begin
                    errors++;
                    $display("FAIL model_cmp dut%0d t=%0t got rgbp=%b expected %b",
                             k, $time, dut_o[k], m_exp[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_ps(input int k, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut_o[k][0] !== 1'b1 && n < budget);
        chk("period_start_seen", int'(dut_o[k][0]), 1);
    endtask

    task automatic window(input int k, input int n, input int chg_at, input logic [7:0] chg_val,
                          output int cr, output int cg, output int cb, output int ps_end);
        cr = 0; cg = 0; cb = 0; ps_end = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == chg_at) g_duty = chg_val;
            cr += int'(dut_o[k][3]);
            cg += int'(dut_o[k][2]);
            cb += int'(dut_o[k][1]);
            ps_end = int'(dut_o[k][0]);
        end
    endtask

    initial begin
        int n, cr, cg, cb, pe;
        logic [7:0] v;

        @(posedge clk);
        chk_on = 1'b1;

        // Reset levels
        repeat (3) @(negedge clk);
        chk("rst_a", int'(dut_o[0]), 0);
        chk("rst_b", int'(dut_o[1]), 0);
        chk("rst_c_active_low", int'(dut_o[2]), 4'b1110);

        // Release with en=1; first pulse one full period later
        r_duty = 8'd255; g_duty = 8'd97; b_duty = 8'd0;
        rst = 1'b1;
        wait_ps(0, 600, n);
        chk("first_ps_latency_a", n, 256);

        window(0, 256, -1, 8'd0, cr, cg, cb, pe);
        chk("w1_r", cr, 256); chk("w1_g", cg, 97); chk("w1_b", cb, 0); chk("w1_ps", pe, 1);

        // Mid-period change ignored until the wrap
        window(0, 256, 49, 8'd200, cr, cg, cb, pe);
        chk("w2_g_mid_change", cg, 97); chk("w2_ps", pe, 1);

        // Change exactly on the wrap cycle is captured
        window(0, 256, 254, 8'd50, cr, cg, cb, pe);
        chk("w3_g", cg, 200);
        window(0, 256, -1, 8'd0, cr, cg, cb, pe);
        chk("w4_g_wrap_capture", cg, 50);

        // en dropped at step 120
        repeat (120) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_a", int'(dut_o[0]), 0);
        chk("en_off_c", int'(dut_o[2]), 4'b1110);
        r_duty = 8'd8; g_duty = 8'd46; b_duty = 8'd84;
        repeat (2) @(negedge clk);
        en = 1'b1;
        window(0, 256, -1, 8'd0, cr, cg, cb, pe);
        chk("en_on_r", cr, 8); chk("en_on_g", cg, 46); chk("en_on_b", cb, 84);
        chk("en_on_first_ps", pe, 1);

        // CLK_DIV=4 instance
        g_duty = 8'd160;
        wait_ps(1, 2000, n);
        chk("b_first_ps_after_en", n, 768);
        window(1, 1024, -1, 8'd0, cr, cg, cb, pe);
        chk("b_g_160", cg, 640); chk("b_r_8", cr, 32); chk("b_b_84", cb, 336);
        chk("b_ps_spacing", pe, 1);

        // Active-low instance: full duty is constant 0, zero duty constant 1
        r_duty = 8'd255; g_duty = 8'd0; b_duty = 8'd0;
        repeat (1600) @(negedge clk);
        window(2, 300, -1, 8'd0, cr, cg, cb, pe);
        chk("c_r255_low", cr, 0); chk("c_g0_high", cg, 300); chk("c_b0_high", cb, 300);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        chk("pre_async_c_r", int'(pr_c), 0);
        chk("pre_async_a_r", int'(pr_a), 1);
        rst = 1'b0;
        #1;
        chk("async_c", int'(dut_o[2]), 4'b1110);
        chk("async_a", int'(dut_o[0]), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0:       v = 8'd0;
                    1:       v = 8'd255;
                    default: v = 8'($urandom_range(255));
                endcase
                case ($urandom_range(2))
                    0:       r_duty = v;
                    1:       g_duty = v;
                    default: b_duty = v;
                endcase
            end
            if ($urandom_range(299) == 0) en = ~en;
            if ($urandom_range(999) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
